// File: rtl/qisp_sched_pkg.sv
// Shared types for the two-task fetch scheduler: per-task state, scheduler FSM
// state, task id constants and a saturating counter helper.
package qisp_sched_pkg;

  typedef enum logic [1:0] {
    TASK_OFF  = 2'd0,
    TASK_RUN  = 2'd1,
    TASK_WAIT = 2'd2
  } task_state_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_IDLE = 2'd2
  } fsm_state_e;

  localparam logic TS_0 = 1'b0;
  localparam logic TS_1 = 1'b1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/task_sched_slot.sv
// One task context: OFF/RUN/WAIT state plus the saturating WAIT timeout counter.
// runnable_nxt exposes the state the task will hold after this clock edge.
module task_slot
  import qisp_sched_pkg::*;
#(
  parameter logic       TS           = TS_0,
  parameter logic [7:0] WAIT_TIMEOUT = 8'd0
) (
  input  logic clk,
  input  logic a_rst,
  input  logic en,
  input  logic wait_req,
  input  logic wait_ts,
  input  logic wake,
  output logic runnable,
  output logic runnable_nxt
);

  localparam task_state_e RST_STATE = (TS == TS_0) ? TASK_RUN : TASK_OFF;

  task_state_e state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        timeout;

  assign timeout = (WAIT_TIMEOUT != 8'd0) && (cnt == WAIT_TIMEOUT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!en) begin
      state_nxt = TASK_OFF;
    end else begin
      case (state)
        TASK_OFF: state_nxt = TASK_RUN;
        TASK_RUN: begin
          // A wake arriving with the wait request keeps the task running.
          if (wait_req && (wait_ts == TS) && !wake) begin
            state_nxt = TASK_WAIT;
            cnt_nxt   = 8'd0;
          end
        end
        TASK_WAIT: begin
          if (wake || timeout) state_nxt = TASK_RUN;
          else                 cnt_nxt   = sat_inc8(cnt);
        end
        default: state_nxt = TASK_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state <= RST_STATE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign runnable     = (state == TASK_RUN);
  assign runnable_nxt = (state_nxt == TASK_RUN);

endmodule

// File: rtl/task_sched.sv
// Two-task fetch scheduler driving the dual-context PC file selectors.
// Define TASK_SCHED_PRIO_EN for strict task-0 priority instead of round-robin.
module task_sched
  import qisp_sched_pkg::*;
#(
  parameter logic [15:0] T1_START     = 16'h0100,
  parameter logic [7:0]  WAIT_TIMEOUT = 8'd0
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        stall,
  input  logic [1:0]  task_en,
  input  logic        br_valid,
  input  logic        br_ts,
  input  logic [15:0] br_target,
  input  logic        wait_req,
  input  logic        wait_ts,
  input  logic [1:0]  wake,
  output logic        r_ts,
  output logic        w_ts,
  output logic        ws,
  output logic        hold,
  output logic [15:0] pc_wr,
  output logic        fetch_valid,
  output logic        dec_valid,
  output logic        dec_ts,
  output logic [1:0]  squash
);

  fsm_state_e fsm, fsm_nxt;
  logic       boot;
  logic [1:0] run, run_nxt;
  logic       other_ts, arb_ts, r_ts_nxt, fetch_valid_nxt;

  task_slot #(.TS(TS_0), .WAIT_TIMEOUT(WAIT_TIMEOUT)) u_slot0 (
    .clk          (clk),
    .a_rst        (a_rst),
    .en           (task_en[0]),
    .wait_req     (wait_req),
    .wait_ts      (wait_ts),
    .wake         (wake[0]),
    .runnable     (run[0]),
    .runnable_nxt (run_nxt[0])
  );

  task_slot #(.TS(TS_1), .WAIT_TIMEOUT(WAIT_TIMEOUT)) u_slot1 (
    .clk          (clk),
    .a_rst        (a_rst),
    .en           (task_en[1]),
    .wait_req     (wait_req),
    .wait_ts      (wait_ts),
    .wake         (wake[1]),
    .runnable     (run[1]),
    .runnable_nxt (run_nxt[1])
  );

  assign other_ts = ~r_ts;

  // Arbitration looks at post-edge task state so a task entering WAIT never fetches next cycle.
  always_comb begin
`ifdef TASK_SCHED_PRIO_EN
    if (run_nxt[TS_0])      arb_ts = TS_0;
    else if (run_nxt[TS_1]) arb_ts = TS_1;
    else                    arb_ts = r_ts;
`else
    if (run_nxt[other_ts]) arb_ts = other_ts;
    else                   arb_ts = r_ts;
`endif
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      ST_INIT: if (!boot) fsm_nxt = ST_RUN;
      ST_RUN:  if (run_nxt == 2'b00) fsm_nxt = ST_IDLE;
      ST_IDLE: if (run != 2'b00) fsm_nxt = ST_RUN;
      default: fsm_nxt = ST_INIT;
    endcase
    r_ts_nxt        = (boot || stall) ? r_ts : arb_ts;
    fetch_valid_nxt = boot | ((fsm_nxt != ST_IDLE) & run_nxt[r_ts_nxt]);
  end

  // Redirect outranks both the INIT start-address write and the stall hold.
  always_comb begin
    ws     = 1'b0;
    w_ts   = TS_0;
    pc_wr  = 16'h0000;
    hold   = 1'b1;
    squash = 2'b00;
    if (!boot) begin
      if (br_valid) begin
        ws     = 1'b1;
        w_ts   = br_ts;
        pc_wr  = br_target;
        hold   = 1'b0;
        squash = br_ts ? 2'b10 : 2'b01;
      end else if (fsm == ST_INIT) begin
        ws     = 1'b1;
        w_ts   = TS_1;
        pc_wr  = {T1_START[15:1], 1'b0};
        hold   = 1'b0;
      end else begin
        hold   = stall | (fsm == ST_IDLE);
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      boot        <= 1'b1;
      fsm         <= ST_INIT;
      r_ts        <= TS_0;
      fetch_valid <= 1'b0;
      dec_ts      <= TS_0;
      dec_valid   <= 1'b0;
    end else begin
      boot        <= 1'b0;
      fsm         <= fsm_nxt;
      r_ts        <= r_ts_nxt;
      fetch_valid <= fetch_valid_nxt;
      // fetch -> decode stage
      dec_ts      <= r_ts;
      dec_valid   <= fetch_valid & ~squash[r_ts];
    end
  end

endmodule
